// File: rtl/snes_pad_reader_pkg.sv
// Shared definitions for the SNES gamepad reader: button indices,
// FSM state encoding, timing defaults and small helper functions.
package snes_pad_reader_pkg;

   // Button positions in the 12-bit active-high buttons vector
   localparam int BTN_B      = 0;
   localparam int BTN_Y      = 1;
   localparam int BTN_SELECT = 2;
   localparam int BTN_START  = 3;
   localparam int BTN_UP     = 4;
   localparam int BTN_DOWN   = 5;
   localparam int BTN_LEFT   = 6;
   localparam int BTN_RIGHT  = 7;
   localparam int BTN_A      = 8;
   localparam int BTN_X      = 9;
   localparam int BTN_L      = 10;
   localparam int BTN_R      = 11;

   // Timing defaults for a 25 MHz vga_clk
   localparam int DEF_CLK_HZ    = 25_000_000;
   localparam int DEF_LATCH_CYC = 300;
   localparam int DEF_HALF_CYC  = 150;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LATCH  = 3'd1,
      ST_CLK_LO = 3'd2,
      ST_CLK_HI = 3'd3,
      ST_DONE   = 3'd4
   } snes_state_e;

   // Counter width able to hold 0..n-1, never narrower than one bit
   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // Direction outputs {right, left, down, up}: suppressed for a bad
   // frame, and opposite pairs cancel each other out.
   function automatic logic [3:0] resolve_dirs(input logic [11:0] btn, input logic ok);
      logic up, dn, lf, rt;
      up = btn[BTN_UP]    & ~btn[BTN_DOWN];
      dn = btn[BTN_DOWN]  & ~btn[BTN_UP];
      lf = btn[BTN_LEFT]  & ~btn[BTN_RIGHT];
      rt = btn[BTN_RIGHT] & ~btn[BTN_LEFT];
      return ok ? {rt, lf, dn, up} : 4'b0000;
   endfunction

endpackage

// File: rtl/snes_sync2.sv
// Two-flop synchroniser for the pad's serial data line. Resets to 1,
// the released/idle wire level, so reset never looks like a press.
module snes_sync2
   import snes_pad_reader_pkg::*;
(
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // Two-stage capture of the asynchronous pad data
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/snes_pad_reader.sv
// SNES gamepad poller: latches the pad at a fixed rate, clocks out the
// 16-bit button word and presents registered active-high button levels.
// Optional macro SNES_DEBOUNCE_EN: outputs only load when two
// consecutive frames carry the identical raw word.
module snes_pad_reader
   import snes_pad_reader_pkg::*;
#(
   parameter int CLK_HZ    = DEF_CLK_HZ,
   parameter int POLL_CYC  = CLK_HZ / 60,
   parameter int LATCH_CYC = DEF_LATCH_CYC,
   parameter int HALF_CYC  = DEF_HALF_CYC
)(
   input  logic        vga_clk,
   input  logic        reset_n,
   input  logic        snes_data,
   output logic        snes_latch,
   output logic        snes_clk,
   output logic        up,
   output logic        down,
   output logic        left,
   output logic        right,
   output logic [11:0] buttons,
   output logic        pad_ok,
   output logic        frame_valid
);

   localparam int TW   = cnt_width(POLL_CYC);
   localparam int PH_W = cnt_width((LATCH_CYC > HALF_CYC) ? LATCH_CYC : HALF_CYC);

   localparam logic [TW-1:0]   POLL_LAST  = TW'(POLL_CYC - 1);
   localparam logic [PH_W-1:0] LATCH_LAST = PH_W'(LATCH_CYC - 1);
   localparam logic [PH_W-1:0] HALF_LAST  = PH_W'(HALF_CYC - 1);

   logic [TW-1:0]   timer_q, timer_d;
   logic            start_req;
   snes_state_e     state_q;
   logic [PH_W-1:0] phase_q;
   logic [3:0]      cnt_q;
   logic [15:0]     shift_q;
   logic            data_s;
   logic            load_ok;
   logic            latch_q, sclk_q, fv_q, ok_q;
   logic [11:0]     btn_q;
   logic [3:0]      dir_q;
   logic [11:0]     word_btn;
   logic            word_ok;
   logic [3:0]      word_dir;

   snes_sync2 u_sync (
      .clk_i  (vga_clk),
      .rst_ni (reset_n),
      .d_i    (snes_data),
      .q_o    (data_s)
   );

   // Free-running poll timer; the wrap cycle requests a new frame
   always_comb begin
      timer_d = timer_q + 1'b1;
      if (timer_q == POLL_LAST) timer_d = '0;
   end

   assign start_req = (timer_q == POLL_LAST);

   // Poll timer register
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) timer_q <= '0;
      else          timer_q <= timer_d;
   end

   // Decode of the completed frame: wire level 0 means pressed
   assign word_btn = ~shift_q[11:0];
   assign word_ok  = &shift_q[15:12];
   assign word_dir = resolve_dirs(word_btn, word_ok);

`ifdef SNES_DEBOUNCE_EN
   logic [15:0] prev_q;

   assign load_ok = (shift_q == prev_q);

   // Remember every frame's raw word, loaded or not
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n)                prev_q <= 16'hFFFF;
      else if (state_q == ST_DONE) prev_q <= shift_q;
   end
`else
   assign load_ok = 1'b1;
`endif

   // Frame sequencer with registered pad strobes and button outputs
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         phase_q <= '0;
         cnt_q   <= '0;
         shift_q <= 16'hFFFF;
         latch_q <= 1'b0;
         sclk_q  <= 1'b1;
         fv_q    <= 1'b0;
         ok_q    <= 1'b0;
         btn_q   <= '0;
         dir_q   <= '0;
      end else begin
         fv_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               latch_q <= 1'b0;
               sclk_q  <= 1'b1;
               if (start_req) begin
                  state_q <= ST_LATCH;
                  latch_q <= 1'b1;
                  phase_q <= '0;
               end
            end
            ST_LATCH: begin
               if (phase_q == LATCH_LAST) begin
                  state_q <= ST_CLK_LO;
                  latch_q <= 1'b0;
                  sclk_q  <= 1'b0;
                  phase_q <= '0;
               end else begin
                  phase_q <= phase_q + 1'b1;
               end
            end
            ST_CLK_LO: begin
               // Sampling a full half period after the last edge leaves
               // time for the pad output plus the synchroniser delay.
               if (phase_q == HALF_LAST) begin
                  shift_q[cnt_q] <= data_s;
                  state_q        <= ST_CLK_HI;
                  sclk_q         <= 1'b1;
                  phase_q        <= '0;
               end else begin
                  phase_q <= phase_q + 1'b1;
               end
            end
            ST_CLK_HI: begin
               if (phase_q == HALF_LAST) begin
                  phase_q <= '0;
                  if (cnt_q == 4'd15) begin
                     state_q <= ST_DONE;
                     fv_q    <= load_ok;
                  end else begin
                     cnt_q   <= cnt_q + 1'b1;
                     state_q <= ST_CLK_LO;
                     sclk_q  <= 1'b0;
                  end
               end else begin
                  phase_q <= phase_q + 1'b1;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               cnt_q   <= '0;
               if (load_ok) begin
                  btn_q <= word_btn;
                  ok_q  <= word_ok;
                  dir_q <= word_dir;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               latch_q <= 1'b0;
               sclk_q  <= 1'b1;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign snes_latch  = latch_q;
   assign snes_clk    = sclk_q;
   assign frame_valid = fv_q;
   assign pad_ok      = ok_q;
   assign buttons     = btn_q;
   assign up          = dir_q[0];
   assign down        = dir_q[1];
   assign left        = dir_q[2];
   assign right       = dir_q[3];

endmodule
